// File: rtl/recip_core_multi.sv
// recip_core_multi: multi-channel reciprocal frequency counter.
// Each channel counts clk_fast cycles between its first and N-th sensor rising
// edge, with an optional per-measurement timeout. Finished channels are drained
// through a round-robin arbiter into a single valid/ready result register.
//
// Ports:
//   clk_fast, rst        measurement clock, asynchronous active-high reset
//   enable               allows new measurements; low aborts those in progress
//   sensor[NUM_CH]       asynchronous sensor inputs
//   n_cycles             rising edges per measurement, latched at start
//   timeout_cycles       coarse limit, sampled live; 0 disables the timeout
//   busy[NUM_CH]         channel is measuring or holding a result
//   res_valid/res_ready  result handshake
//   res_ch, res_coarse, res_edges, res_timeout   result fields
//
// Channel FSM states:
//   state   | meaning
//   IDLE    | waiting for a start edge while enable is high
//   MEAS    | counting clk_fast cycles and sensor edges
//   DONE    | result held until the arbiter grants the channel

module recip_core_multi #(
    parameter int NUM_CH       = 4,
    parameter int COARSE_WIDTH = 24,
    parameter int NCNT_WIDTH   = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk_fast,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       sensor,
    input  logic [NCNT_WIDTH-1:0]   n_cycles,
    input  logic [COARSE_WIDTH-1:0] timeout_cycles,
    output logic [NUM_CH-1:0]       busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CH_W-1:0]         res_ch,
    output logic [COARSE_WIDTH-1:0] res_coarse,
    output logic [NCNT_WIDTH-1:0]   res_edges,
    output logic                    res_timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEAS = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [SYNC_STAGES-1:0]  sync_q [NUM_CH];
    logic [1:0]              state  [NUM_CH];
    logic [COARSE_WIDTH-1:0] coarse [NUM_CH];
    logic [NCNT_WIDTH-1:0]   edges  [NUM_CH];
    logic [NCNT_WIDTH-1:0]   n_lat  [NUM_CH];
    logic [NUM_CH-1:0]       tmo_flag;
    logic [NUM_CH-1:0]       sync_now, sync_d, edge_pulse;
    logic [NUM_CH-1:0]       stop_hit, tmo_hit, sat_hit;
    logic [NUM_CH-1:0]       done_vec, grant_vec;
    logic [CH_W-1:0]         rr_ptr, grant_ch;
    logic                    grant_any, load;

    assign edge_pulse = sync_now & ~sync_d;

    always_comb begin
        sync_now = '0;
        done_vec = '0;
        busy     = '0;
        stop_hit = '0;
        tmo_hit  = '0;
        sat_hit  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sync_now[i] = sync_q[i][SYNC_STAGES-1];
            done_vec[i] = (state[i] == ST_DONE);
            busy[i]     = (state[i] != ST_IDLE);
            stop_hit[i] = edge_pulse[i] && (edges[i] == n_lat[i] - NCNT_WIDTH'(1));
            tmo_hit[i]  = (timeout_cycles != '0) &&
                          (coarse[i] + COARSE_WIDTH'(1) == timeout_cycles);
            // With no timeout the counter must not wrap; park at all-ones.
            sat_hit[i]  = (timeout_cycles == '0) && (coarse[i] == '1);
        end
    end

    // Round-robin: first DONE channel at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_ch  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_CH;
            if (!grant_any && done_vec[CH_W'(idx)]) begin
                grant_any = 1'b1;
                grant_ch  = CH_W'(idx);
            end
        end
    end

    assign load = (!res_valid || res_ready) && grant_any;

    always_comb begin
        grant_vec = '0;
        if (load)
            grant_vec[grant_ch] = 1'b1;
    end

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            sync_d   <= '0;
            tmo_flag <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sync_q[i] <= '0;
                state[i]  <= ST_IDLE;
                coarse[i] <= '0;
                edges[i]  <= '0;
                n_lat[i]  <= '0;
            end
        end else begin
            sync_d <= sync_now;
            for (int i = 0; i < NUM_CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sensor[i]};
                case (state[i])
                    ST_IDLE: begin
                        if (enable && edge_pulse[i]) begin
                            state[i]  <= ST_MEAS;
                            coarse[i] <= '0;
                            edges[i]  <= NCNT_WIDTH'(1);
                            // Fewer than two edges cannot define a period.
                            n_lat[i]  <= (n_cycles < NCNT_WIDTH'(2)) ? NCNT_WIDTH'(2) : n_cycles;
                        end
                    end
                    ST_MEAS: begin
                        if (!enable) begin
                            state[i] <= ST_IDLE;
                        end else if (stop_hit[i]) begin
                            state[i]    <= ST_DONE;
                            coarse[i]   <= coarse[i] + COARSE_WIDTH'(1);
                            edges[i]    <= n_lat[i];
                            tmo_flag[i] <= 1'b0;
                        end else if (tmo_hit[i]) begin
                            state[i]    <= ST_DONE;
                            coarse[i]   <= timeout_cycles;
                            tmo_flag[i] <= 1'b1;
                        end else if (sat_hit[i]) begin
                            state[i]    <= ST_DONE;
                            tmo_flag[i] <= 1'b1;
                        end else begin
                            coarse[i] <= coarse[i] + COARSE_WIDTH'(1);
                            if (edge_pulse[i])
                                edges[i] <= edges[i] + NCNT_WIDTH'(1);
                        end
                    end
                    ST_DONE: begin
                        if (grant_vec[i])
                            state[i] <= ST_IDLE;
                    end
                    default: state[i] <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_coarse  <= '0;
            res_edges   <= '0;
            res_timeout <= 1'b0;
        end else if (load) begin
            rr_ptr      <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
            res_valid   <= 1'b1;
            res_ch      <= grant_ch;
            res_coarse  <= coarse[grant_ch];
            res_edges   <= edges[grant_ch];
            res_timeout <= tmo_flag[grant_ch];
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
